// File: rtl/jtcps1_gfx_romreq.sv
// CPS1 graphics tile-row ROM fetch: latches a request, asks the bank mapper for
// the upper address nibble, then holds a ROM request until the word arrives.
module jtcps1_gfx_romreq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  layer,
    input  logic [15:0] code,
    input  logic [3:0]  vrow,
    output logic        busy,
    output logic        ack,
    output logic [31:0] data,
    output logic        map_en,
    output logic [2:0]  map_layer,
    output logic [9:0]  map_cin,
    input  logic [3:0]  map_offset,
    input  logic [3:0]  map_mask,
    output logic        rom_cs,
    output logic [19:0] rom_addr,
    input  logic        rom_ok,
    input  logic [31:0] rom_data
);

    // state  | meaning
    // IDLE   | waiting for req (ignored while ack is still high)
    // MAP    | map_en high, mapper sees latched layer / code[15:6]
    // SAMPLE | mapper offset/mask valid, upper nibble registered
    // ROM    | first rom_cs cycle, rom_ok ignored (may be stale)
    // WAIT   | rom_cs held until rom_ok
    typedef enum logic [2:0] {IDLE, MAP, SAMPLE, ROM, WAIT} state_t;

    state_t      state, next_state;
    logic [15:0] code_l;
    logic [3:0]  vrow_l;
    logic [3:0]  hi;
    logic        accept;
    logic        fetch_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        fetch_done = 1'b0;
        map_en     = 1'b0;
        rom_cs     = 1'b0;
        case (state)
            IDLE: begin
                if (req && !ack) begin
                    accept     = 1'b1;
                    next_state = MAP;
                end
            end
            MAP: begin
                map_en     = 1'b1;
                next_state = SAMPLE;
            end
            SAMPLE: next_state = ROM;
            ROM: begin
                rom_cs     = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                rom_cs = 1'b1;
                if (rom_ok) begin
                    fetch_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ack is the final busy cycle even though the FSM is already back in IDLE
    assign busy     = (state != IDLE) || ack;
    assign rom_addr = {hi, code_l[11:0], vrow_l};

    always_ff @(posedge clk) begin
        if (rst) begin
            code_l    <= 16'd0;
            vrow_l    <= 4'd0;
            hi        <= 4'd0;
            map_layer <= 3'd0;
            map_cin   <= 10'd0;
            ack       <= 1'b0;
            data      <= 32'd0;
        end else begin
            ack <= fetch_done;
            if (accept) begin
                code_l    <= code;
                vrow_l    <= vrow;
                map_layer <= layer;
                map_cin   <= code[15:6];
            end
            if (state == SAMPLE)
                hi <= (code_l[15:12] & map_mask) | map_offset;
            if (fetch_done)
                data <= rom_data;
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_romreq.sv
// Directed bench for jtcps1_gfx_romreq: fixed scenarios with hand-computed
// addresses, latencies and pulse counts.
module tb_jtcps1_gfx_romreq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  layer = 3'd0;
    logic [15:0] code = 16'd0;
    logic [3:0]  vrow = 4'd0;
    logic        busy, ack, map_en, rom_cs;
    logic [31:0] data;
    logic [2:0]  map_layer;
    logic [9:0]  map_cin;
    logic [19:0] rom_addr;
    logic [3:0]  map_offset = 4'd0;
    logic [3:0]  map_mask = 4'hF;
    logic        rom_ok = 1'b0;
    logic [31:0] rom_data = 32'd0;

    int vectors = 0;
    int miscompares = 0;
    int n_map = 0;
    int n_ack = 0;
    int n_cs = 0;
    int cyc = 0;

    jtcps1_gfx_romreq dut (
        .clk(clk), .rst(rst), .req(req), .layer(layer), .code(code), .vrow(vrow),
        .busy(busy), .ack(ack), .data(data), .map_en(map_en),
        .map_layer(map_layer), .map_cin(map_cin),
        .map_offset(map_offset), .map_mask(map_mask),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (map_en) n_map++;
        if (ack)    n_ack++;
        if (rom_cs) n_cs++;
    endtask

    // leaves the bench in the MAP cycle of the new request
    task automatic start_req(input logic [2:0] l, input logic [15:0] c, input logic [3:0] v);
        layer = l; code = c; vrow = v; req = 1'b1;
        tick;
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; layer = 3'd2; code = 16'hFFFF; vrow = 4'hF;
        tick; tick;
        rst = 1'b0; req = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ack); end
        vectors++; if (map_en !== 1'b0) begin miscompares++; $display("FAIL reset_map_en: got %b expected 0", map_en); end
        vectors++; if (rom_cs !== 1'b0) begin miscompares++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
        vectors++; if (data !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", data); end
        vectors++; if (rom_addr !== 20'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
        vectors++; if (map_layer !== 3'd0) begin miscompares++; $display("FAIL reset_map_layer: got %h expected 0", map_layer); end
        vectors++; if (map_cin !== 10'd0) begin miscompares++; $display("FAIL reset_map_cin: got %h expected 0", map_cin); end
        tick;
        vectors++; if ({busy, map_en} !== 2'b00) begin miscompares++; $display("FAIL req_during_rst: busy,map_en got %b expected 00", {busy, map_en}); end
    endtask

    task automatic test_basic;
        map_offset = 4'h0; map_mask = 4'hF; rom_ok = 1'b0;
        start_req(3'b010, 16'h1234, 4'h5);
        vectors++; if ({map_en, busy} !== 2'b11) begin miscompares++; $display("FAIL s1_map_cycle: map_en,busy got %b expected 11", {map_en, busy}); end
        vectors++; if (map_cin !== 10'h048) begin miscompares++; $display("FAIL s1_map_cin: got %h expected 048", map_cin); end
        vectors++; if (map_layer !== 3'b010) begin miscompares++; $display("FAIL s1_map_layer: got %b expected 010", map_layer); end
        tick;
        vectors++; if (map_en !== 1'b0) begin miscompares++; $display("FAIL s1_map_en_one_cycle: got %b expected 0", map_en); end
        tick;
        vectors++; if ({rom_cs, rom_addr} !== {1'b1, 20'h12345}) begin miscompares++; $display("FAIL s1_rom_addr: cs,addr got %b %h expected 1 12345", rom_cs, rom_addr); end
        tick;
        rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
        vectors++; if ({rom_cs, ack} !== 2'b10) begin miscompares++; $display("FAIL s1_wait: cs,ack got %b expected 10", {rom_cs, ack}); end
        tick;
        rom_ok = 1'b0; rom_data = 32'h0;
        vectors++; if ({ack, rom_cs, busy} !== 3'b101) begin miscompares++; $display("FAIL s1_ack_cycle5: ack,cs,busy got %b expected 101", {ack, rom_cs, busy}); end
        vectors++; if (data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL s1_data: got %h expected deadbeef", data); end
        tick;
        vectors++; if ({ack, busy} !== 2'b00) begin miscompares++; $display("FAIL s1_after_ack: ack,busy got %b expected 00", {ack, busy}); end
        vectors++; if ({map_cin, data} !== {10'h048, 32'hDEADBEEF}) begin miscompares++; $display("FAIL s1_hold: cin,data got %h %h expected 048 deadbeef", map_cin, data); end
    endtask

    task automatic check_addr(input logic [2:0] l, input logic [15:0] c, input logic [3:0] v,
                              input logic [3:0] off, input logic [3:0] msk, input logic [19:0] exp_addr);
        map_offset = off; map_mask = msk; rom_ok = 1'b1;
        start_req(l, c, v);
        vectors++; if (map_layer !== l) begin miscompares++; $display("FAIL addr_map_layer: got %b expected %b", map_layer, l); end
        tick; tick;
        vectors++; if (rom_addr !== exp_addr) begin miscompares++; $display("FAIL addr_%h: got %h expected %h", exp_addr, rom_addr, exp_addr); end
        tick; tick;
        rom_ok = 1'b0;
        tick;
        map_offset = 4'h0; map_mask = 4'hF;
    endtask

    task automatic test_mapper;
        check_addr(3'b000, 16'hABCD, 4'h7, 4'h4, 4'h3, 20'h6BCD7);
        check_addr(3'b100, 16'hFFFF, 4'hF, 4'h9, 4'h0, 20'h9FFFF);
        check_addr(3'b011, 16'hFFFF, 4'hF, 4'h0, 4'hF, 20'hFFFFF);
        check_addr(3'b001, 16'h3000, 4'h0, 4'h8, 4'hF, 20'hB0000);
    endtask

    task automatic test_ok_held;
        rom_ok = 1'b1; rom_data = 32'h0BADF00D;
        n_cs = 0; n_ack = 0;
        start_req(3'b001, 16'h4321, 4'h2);
        for (int i = 0; i < 8; i++) tick;
        rom_ok = 1'b0;
        vectors++; if (n_cs !== 2) begin miscompares++; $display("FAIL s3_rom_cs_cycles: got %0d expected 2", n_cs); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL s3_ack_count: got %0d expected 1", n_ack); end
        vectors++; if (data !== 32'h0BADF00D) begin miscompares++; $display("FAIL s3_data: got %h expected 0badf00d", data); end
    endtask

    task automatic test_long_wait;
        rom_ok = 1'b0;
        start_req(3'b001, 16'h5A5A, 4'h3);
        tick; tick; tick;
        n_map = 0; n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if ({rom_cs, busy, rom_addr} !== {1'b1, 1'b1, 20'h5A5A3}) begin
                miscompares++;
                $display("FAIL s4_wait_%0d: cs,busy,addr got %b %b %h expected 1 1 5a5a3", i, rom_cs, busy, rom_addr);
            end
            req = (i % 4 == 1);
            tick;
            req = 1'b0;
        end
        rom_ok = 1'b1; rom_data = 32'h12345678;
        tick;
        rom_ok = 1'b0; req = 1'b1;
        tick;
        req = 1'b0;
        vectors++; if ({map_en, busy} !== 2'b00) begin miscompares++; $display("FAIL s4_req_on_ack: map_en,busy got %b expected 00", {map_en, busy}); end
        tick;
        vectors++; if (n_map !== 0) begin miscompares++; $display("FAIL s4_extra_map_en: got %0d expected 0", n_map); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL s4_ack_count: got %0d expected 1", n_ack); end
        vectors++; if (data !== 32'h12345678) begin miscompares++; $display("FAIL s4_data: got %h expected 12345678", data); end
    endtask

    task automatic test_reset_in_wait;
        int lat;
        rom_ok = 1'b0;
        start_req(3'b011, 16'h0F0F, 4'h1);
        tick; tick;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++; if ({rom_cs, ack, busy} !== 3'b000) begin miscompares++; $display("FAIL s5_after_rst: cs,ack,busy got %b expected 000", {rom_cs, ack, busy}); end
        vectors++; if (data !== 32'd0) begin miscompares++; $display("FAIL s5_data_cleared: got %h expected 0", data); end
        n_ack = 0;
        rom_ok = 1'b1; rom_data = 32'hCAFEBABE;
        tick;
        rom_ok = 1'b0;
        tick; tick;
        vectors++; if (n_ack !== 0) begin miscompares++; $display("FAIL s5_stale_ok_ack: got %0d expected 0", n_ack); end
        rom_ok = 1'b1; rom_data = 32'h600DD00D;
        start_req(3'b011, 16'h0F0F, 4'h1);
        lat = 1;
        while (!ack && lat < 30) begin tick; lat++; end
        rom_ok = 1'b0;
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL s5_latency: got %0d expected 5", lat); end
        vectors++; if (data !== 32'h600DD00D) begin miscompares++; $display("FAIL s5_data: got %h expected 600dd00d", data); end
        tick;
    endtask

    task automatic test_back_to_back;
        int t1, t2, lat;
        rom_ok = 1'b1; rom_data = 32'h11111111;
        n_map = 0; n_ack = 0;
        start_req(3'b000, 16'h0001, 4'h0);
        lat = 1;
        while (!ack && lat < 30) begin tick; lat++; end
        t1 = cyc;
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 5", lat); end
        rom_data = 32'h22222222;
        tick;
        start_req(3'b010, 16'h0002, 4'h1);
        lat = 1;
        while (!ack && lat < 30) begin tick; lat++; end
        t2 = cyc;
        rom_ok = 1'b0;
        tick;
        vectors++; if (t2 - t1 !== 6) begin miscompares++; $display("FAIL b2b_ack_spacing: got %0d expected 6", t2 - t1); end
        vectors++; if (n_map !== 2) begin miscompares++; $display("FAIL b2b_map_en_count: got %0d expected 2", n_map); end
        vectors++; if (n_ack !== 2) begin miscompares++; $display("FAIL b2b_ack_count: got %0d expected 2", n_ack); end
        vectors++; if (data !== 32'h22222222) begin miscompares++; $display("FAIL b2b_data: got %h expected 22222222", data); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mapper;
        test_ok_held;
        test_long_wait;
        test_reset_in_wait;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtcps1_gfx_romreq.md
JTCPS1_GFX_ROMREQ -- requirements
Module: jtcps1_gfx_romreq

Interface
REQ-001 Reset is synchronous and active-high: port `rst` is sampled only on the rising edge of `clk`, and everything runs on that single clock.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  1  tile-row fetch request, single-cycle pulse, honoured only when busy=0.
REQ-005 layer  input  3  requesting layer: 000 OBJ, 001 SCR1, 010 SCR2, 011 SCR3, 100 star field.
REQ-006 code  input  16  tile code.
REQ-007 vrow  input  4  pixel row within tile.
REQ-008 busy  output  1  high from the cycle after an accepted req until the cycle ack is high, inclusive.
REQ-009 ack  output  1  one-cycle pulse marking data valid.
REQ-010 data  output  32  fetched ROM word, held stable until the next ack.
REQ-011 map_en  output  1  enable to the bank mapper.
REQ-012 map_layer  output  3  layer presented to the mapper.
REQ-013 map_cin  output  10  code bits presented to the mapper.
REQ-014 map_offset  input  4  mapper bank offset, valid one cycle after map_en.
REQ-015 map_mask  input  4  mapper bank mask, valid one cycle after map_en.
REQ-016 rom_cs  output  1  ROM request, held until served.
REQ-017 rom_addr  output  20  ROM word address, stable while rom_cs=1.
REQ-018 rom_ok  input  1  ROM data-valid qualifier.
REQ-019 rom_data  input  32  ROM read data.

Function
REQ-020 Reset sets these values: FSM=IDLE, busy=0, ack=0, map_en=0, rom_cs=0, data=0, rom_addr=0, map_layer=0, map_cin=0.
REQ-021 The FSM has exactly these states: IDLE, MAP, SAMPLE, ROM, WAIT.
REQ-022 IDLE: on req=1, latch layer, code and vrow; go to MAP; set busy=1 on the next cycle.
REQ-023 IDLE: req=0 causes no state change.
REQ-024 Any req while busy=1 is ignored and not queued.
REQ-025 MAP (one cycle): map_en=1, map_layer=latched layer, map_cin=latched code[15:6]; next state SAMPLE.
REQ-026 map_en is high only in MAP, so exactly one cycle per request.
REQ-027 map_layer and map_cin hold their values from MAP until the next request.
REQ-028 SAMPLE (one cycle): register hi = (code[15:12] & map_mask) | map_offset, 4 bits, bitwise; next state ROM.
REQ-029 ROM: rom_addr = {hi, code[11:0], vrow}, 20 bits; rom_cs=1; next state WAIT.
REQ-030 WAIT: rom_cs stays 1 and rom_addr stays constant.
REQ-031 rom_ok is ignored in the first cycle rom_cs is high (the ROM cycle), which guards against a stale ok from the previous request.
REQ-032 WAIT with rom_ok=1: data <= rom_data; ack=1 in the following cycle; rom_cs=0 in that same cycle; busy=0 in the cycle after ack; return to IDLE.
REQ-033 WAIT with rom_ok=0: remain in WAIT indefinitely; there is no timeout.
REQ-034 Minimum latency from req to ack is 5 cycles (req at cycle n: MAP n+1, SAMPLE n+2, ROM n+3, ok seen in WAIT n+4, ack n+5).
REQ-035 A req asserted in the cycle after ack (FSM back in IDLE) is accepted; back-to-back throughput is one fetch per 6 cycles minimum.
REQ-036 With mapper defaults (offset=0, mask=F), hi equals code[15:12] exactly.
REQ-037 With mask=0, hi equals offset regardless of code.
REQ-038 Address arithmetic is purely bitwise (no carry), so code=FFFF and vrow=F produce no wrap into other fields.
REQ-039 Layer 100 (star field) follows the identical path; no bypass.

Reset
REQ-040 rst=1 in any state (including WAIT with rom_cs=1) forces the REQ-020 values on the next edge.
REQ-041 After reset, rom_cs drops immediately and any in-flight rom_ok or rom_data is discarded.
REQ-042 A req coincident with rst=1 is dropped.

Verification
REQ-043 Scenario 1: req with layer=010, code=1234, vrow=5; mapper offset=0, mask=F; rom_ok at the first legal cycle -> map_cin=048, rom_addr=12345, ack exactly 5 cycles after req, data equal to rom_data.
REQ-044 Scenario 2: code=ABCD, vrow=7; map_mask=3, map_offset=4 -> hi=(A&3)|4=6, rom_addr=6BCD7.
REQ-045 Scenario 3: rom_ok held high continuously -> it is ignored in the ROM cycle; ack=1 once; rom_cs high for exactly 2 cycles.
REQ-046 Scenario 4: rom_ok delayed 20 cycles -> rom_cs and rom_addr stable throughout; busy=1; req pulses during the wait produce no extra map_en or ack.
REQ-047 Scenario 5: rst asserted in the third WAIT cycle, then rom_ok pulsed -> rom_cs=0 after the edge; no ack; data=0; the next req runs the full 5-cycle sequence.
REQ-048 Scenario 6: two requests with the second req one cycle after the first ack -> both accepted; map_en pulses exactly twice; two acks 6 cycles apart with zero-wait ROM.
